// File: rtl/imm_share_arbiter_if.sv
// Requester, generator and response signals of the shared immediate-generator arbiter.
// The slave modport is the arbiter side; the master modport is the requester/generator/consumer side.
interface imm_share_arbiter_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int INST_WIDTH   = 32,
  parameter int IMM_TYPE_NUM = 4,
  parameter int NUM_REQ      = 2
);
  localparam int TW  = $clog2(IMM_TYPE_NUM);
  localparam int IDW = ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*INST_WIDTH-1:0] req_inst;
  logic [NUM_REQ*TW-1:0]         req_imm_type;
  logic [INST_WIDTH-1:0]         gen_inst;
  logic [TW-1:0]                 gen_imm_type;
  logic [DATA_WIDTH-1:0]         gen_imm;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [IDW-1:0]                rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_imm;

  modport slave (
    input  req_valid, req_inst, req_imm_type, gen_imm, rsp_ready,
    output req_ready, gen_inst, gen_imm_type, rsp_valid, rsp_id, rsp_imm
  );

  modport master (
    output req_valid, req_inst, req_imm_type, gen_imm, rsp_ready,
    input  req_ready, gen_inst, gen_imm_type, rsp_valid, rsp_id, rsp_imm
  );
endinterface

// File: rtl/imm_share_arbiter.sv
// Round-robin arbiter sharing one combinational immediate generator, with a one-entry tagged response register.
// Optional per-requester grant/stall counters are built when IMM_ARB_STATS_EN is defined.
module imm_share_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int INST_WIDTH   = 32,
  parameter int IMM_TYPE_NUM = 4,
  parameter int NUM_REQ      = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  imm_share_arbiter_if.slave     bus
`ifdef IMM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]  stat_grant,
  output logic [NUM_REQ*16-1:0]  stat_stall
`endif
);
  localparam int TW  = $clog2(IMM_TYPE_NUM);
  localparam int IDW = ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]        rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_imm_q, rsp_imm_d;
  logic [IDW-1:0]        gnt_idx;
  logic                  found;
  logic                  can_accept;
  logic                  gnt_any;
  logic [NUM_REQ-1:0]    gnt_vec;

  // Scan from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin : arb_scan
    int idx;
    idx     = 0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  // rst_n gates the grant so no requester sees ready while the block is held in reset.
  assign can_accept = (state_q == EMPTY) | bus.rsp_ready;
  assign gnt_any    = found & can_accept & rst_n;

  always_comb begin
    gnt_vec = '0;
    if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
  end

  assign bus.req_ready    = gnt_vec;
  assign bus.gen_inst     = gnt_any ? bus.req_inst[int'(gnt_idx)*INST_WIDTH +: INST_WIDTH] : '0;
  assign bus.gen_imm_type = gnt_any ? bus.req_imm_type[int'(gnt_idx)*TW +: TW] : '0;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    rsp_id_d  = rsp_id_q;
    rsp_imm_d = rsp_imm_q;
    case (state_q)
      EMPTY:   if (gnt_any) state_d = FULL;
      FULL:    if (bus.rsp_ready && !gnt_any) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    // A grant in FULL is only possible with rsp_ready high, so the old entry retires on the same edge.
    if (gnt_any) begin
      rsp_imm_d = bus.gen_imm;
      rsp_id_d  = gnt_idx;
      rr_ptr_d  = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      rr_ptr_q  <= '0;
      rsp_id_q  <= '0;
      rsp_imm_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      rsp_id_q  <= rsp_id_d;
      rsp_imm_q <= rsp_imm_d;
    end
  end

  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_imm   = rsp_imm_q;

`ifdef IMM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  logic [NUM_REQ*16-1:0] stat_grant_q, stat_grant_d;
  logic [NUM_REQ*16-1:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_grant_d = stat_grant_q;
    stat_stall_d = stat_stall_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_grant_d[i*16 +: 16] = sat_inc(stat_grant_q[i*16 +: 16], gnt_vec[i]);
      stat_stall_d[i*16 +: 16] = sat_inc(stat_stall_q[i*16 +: 16], bus.req_valid[i] & ~gnt_vec[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grant_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_grant_q <= stat_grant_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_grant = stat_grant_q;
  assign stat_stall = stat_stall_q;
`endif
endmodule

// File: tb/tb_imm_share_arbiter.sv
// Randomized bench for imm_share_arbiter with a transaction-level reference model and directed literal checks.
// Build with IMM_ARB_STATS_EN defined to also exercise the statistics counters.
module tb_imm_share_arbiter;
  localparam int DW = 32;
  localparam int IW = 32;
  localparam int NR = 2;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  imm_share_arbiter_if #(.DATA_WIDTH(DW), .INST_WIDTH(IW), .IMM_TYPE_NUM(4), .NUM_REQ(NR)) ifc ();

`ifdef IMM_ARB_STATS_EN
  logic [NR*16-1:0] stat_grant;
  logic [NR*16-1:0] stat_stall;
`endif

  imm_share_arbiter #(.DATA_WIDTH(DW), .INST_WIDTH(IW), .IMM_TYPE_NUM(4), .NUM_REQ(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
`ifdef IMM_ARB_STATS_EN
    ,
    .stat_grant (stat_grant),
    .stat_stall (stat_stall)
`endif
  );

  // RISC-V immediate formats: 0=I, 1=S, 2=U, 3=B
  function automatic logic [31:0] imm_of(input logic [31:0] in, input logic [1:0] t);
    case (t)
      2'd0:    return {{20{in[31]}}, in[31:20]};
      2'd1:    return {{20{in[31]}}, in[31:25], in[11:7]};
      2'd2:    return {in[31:12], 12'h000};
      default: return {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
    endcase
  endfunction

  // External generator instance stand-in
  assign ifc.gen_imm = imm_of(ifc.gen_inst, ifc.gen_imm_type);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_rr;
  bit           m_valid;
  int           m_id;
  logic [31:0]  m_imm;
  int           cg;
  int           cidx;
  logic [NR-1:0] cer;
  logic [NR-1:0] last_ready = '0;
  logic [31:0]  cinst;
  logic [1:0]   ctype;
  int           m_sg [NR];
  int           m_ss [NR];

  always @(negedge clk) begin
    cer = '0;
    if (!rst_n) begin
      m_rr = 0; m_valid = 0; m_id = 0; m_imm = '0;
      for (int i = 0; i < NR; i++) begin m_sg[i] = 0; m_ss[i] = 0; end
      chk("rst_req_ready", 64'(ifc.req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    end else begin
      cg = -1;
      if (!m_valid || ifc.rsp_ready) begin
        for (int k = 0; k < NR; k++) begin
          cidx = (m_rr + k) % NR;
          if (cg < 0 && ifc.req_valid[cidx]) cg = cidx;
        end
      end
      cinst = '0;
      ctype = '0;
      if (cg >= 0) begin
        cer[cg] = 1'b1;
        cinst   = ifc.req_inst[cg*IW +: IW];
        ctype   = ifc.req_imm_type[cg*2 +: 2];
      end
      chk("model_req_ready", 64'(ifc.req_ready), 64'(cer));
      chk("model_gen_inst", 64'(ifc.gen_inst), 64'(cinst));
      chk("model_gen_type", 64'(ifc.gen_imm_type), 64'(ctype));
      chk("model_rsp_valid", 64'(ifc.rsp_valid), 64'(m_valid));
      if (m_valid) begin
        chk("model_rsp_id", 64'(ifc.rsp_id), 64'(m_id));
        chk("model_rsp_imm", 64'(ifc.rsp_imm), 64'(m_imm));
      end
`ifdef IMM_ARB_STATS_EN
      for (int i = 0; i < NR; i++) begin
        chk("model_stat_grant", 64'(stat_grant[i*16 +: 16]), 64'(m_sg[i]));
        chk("model_stat_stall", 64'(stat_stall[i*16 +: 16]), 64'(m_ss[i]));
      end
`endif
      for (int i = 0; i < NR; i++) begin
        if (i == cg && m_sg[i] < 65535) m_sg[i]++;
        if (ifc.req_valid[i] && i != cg && m_ss[i] < 65535) m_ss[i]++;
      end
      if (cg >= 0) begin
        m_valid = 1;
        m_id    = cg;
        m_imm   = imm_of(cinst, ctype);
        m_rr    = (cg + 1) % NR;
      end else if (ifc.rsp_ready) begin
        m_valid = 0;
      end
    end
    last_ready = cer;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] inst, input logic [1:0] t);
    ifc.req_valid[i]           = v;
    ifc.req_inst[i*IW +: IW]   = inst;
    ifc.req_imm_type[i*2 +: 2] = t;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst_n            = 1'b0;
    ifc.req_valid    = '1;
    ifc.req_inst     = '0;
    ifc.req_imm_type = '0;
    ifc.rsp_ready    = 1'b1;

    // Reset held with all requesters valid
    at_neg();
    at_neg();
    chk("reset_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    chk("reset_rsp_id", 64'(ifc.rsp_id), 64'd0);
    chk("reset_rsp_imm", 64'(ifc.rsp_imm), 64'd0);
    chk("reset_req_ready", 64'(ifc.req_ready), 64'd0);
    step();
    ifc.req_valid = '0;
    rst_n = 1'b1;

    // Single request, I type
    step();
    set_req(0, 1'b1, 32'hFFF00093, 2'd0);
    at_neg();
    chk("single_req_ready", 64'(ifc.req_ready), 64'h1);
    step();
    ifc.req_valid = '0;
    at_neg();
    chk("single_rsp_valid", 64'(ifc.rsp_valid), 64'd1);
    chk("single_rsp_id", 64'(ifc.rsp_id), 64'd0);
    chk("single_rsp_imm", 64'(ifc.rsp_imm), 64'hFFFFFFFF);

    // Grant requester 1 once so rr_ptr returns to 0, then contention
    step();
    set_req(1, 1'b1, 32'h00700113, 2'd0);
    step();
    set_req(0, 1'b1, 32'h00500093, 2'd0);
    set_req(1, 1'b1, 32'h00700113, 2'd0);
    for (int c = 0; c < 4; c++) begin
      at_neg();
      chk("contend_ready", 64'(ifc.req_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
      chk("contend_rsp_valid", 64'(ifc.rsp_valid), 64'd1);
      chk("contend_rsp_id", 64'(ifc.rsp_id), 64'((c + 1) % 2));
      step();
    end

    // Backpressure: FULL with requester 1's response (imm 7), new U-type request waiting
    ifc.req_valid[0] = 1'b0;
    set_req(1, 1'b1, 32'h12345037, 2'd2);
    ifc.rsp_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      at_neg();
      chk("bp_ready", 64'(ifc.req_ready), 64'd0);
      chk("bp_rsp_valid", 64'(ifc.rsp_valid), 64'd1);
      chk("bp_rsp_id", 64'(ifc.rsp_id), 64'd1);
      chk("bp_rsp_imm", 64'(ifc.rsp_imm), 64'd7);
      step();
    end
    ifc.rsp_ready = 1'b1;
    at_neg();
    chk("bp_release_ready", 64'(ifc.req_ready), 64'h2);
    step();
    ifc.req_valid = '0;
    at_neg();
    chk("bp_u_rsp_id", 64'(ifc.rsp_id), 64'd1);
    chk("bp_u_rsp_imm", 64'(ifc.rsp_imm), 64'h12345000);

    // Reset mid-operation with a grant pending for requester 1
    step();
    set_req(0, 1'b1, 32'h00500093, 2'd0);
    step();
    ifc.req_valid = '1;
    at_neg();
    chk("pre_rst_ready", 64'(ifc.req_ready), 64'h2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    chk("async_rst_rsp_id", 64'(ifc.rsp_id), 64'd0);
    chk("async_rst_rsp_imm", 64'(ifc.rsp_imm), 64'd0);
    chk("async_rst_ready", 64'(ifc.req_ready), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    at_neg();
    chk("post_rst_first_grant", 64'(ifc.req_ready), 64'h1);

`ifdef IMM_ARB_STATS_EN
    // Counters: 10 cycles of contention then 4 backpressured cycles on requester 0
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (10) step();
    ifc.req_valid = 2'b01;
    ifc.rsp_ready = 1'b0;
    chk("stat_grant0", 64'(stat_grant[15:0]), 64'd5);
    chk("stat_grant1", 64'(stat_grant[31:16]), 64'd5);
    repeat (4) step();
    chk("stat_stall0", 64'(stat_stall[15:0]), 64'd9);
    chk("stat_stall1", 64'(stat_stall[31:16]), 64'd5);
`endif

    // Random traffic obeying the hold-while-waiting rule
    for (int n = 0; n < 3000; n++) begin
      step();
      if (n == 1500) begin
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
      end
      for (int i = 0; i < NR; i++) begin
        if (ifc.req_valid[i] && !last_ready[i]) begin
          if ($urandom_range(0, 7) == 0) ifc.req_valid[i] = 1'b0;
        end else begin
          set_req(i, ($urandom_range(0, 2) != 0), $urandom, 2'($urandom_range(0, 3)));
        end
      end
      ifc.rsp_ready = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
    end

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
